addr_mode_sequencer: RTL and testbench

//  Sequences the 16-bit address mux through the multi-cycle 6502 operand/effective-address fetch.

---
 rtl/cpu6502_pkg.sv | 45 ++++
 rtl/addr_mode_sequencer_if.sv | 29 ++
 rtl/addr_mode_sequencer.sv | 165 ++++++++++++++++
 tb/tb_addr_mode_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: addressing-mode codes, address mux select map and
// the operand/effective-address sequencer state encoding.
package cpu6502_pkg;

   localparam logic [2:0] AM_ZP   = 3'd0;
   localparam logic [2:0] AM_ZPX  = 3'd1;
   localparam logic [2:0] AM_ABS  = 3'd2;
   localparam logic [2:0] AM_ABSX = 3'd3;
   localparam logic [2:0] AM_ABSY = 3'd4;
   localparam logic [2:0] AM_INDX = 3'd5;
   localparam logic [2:0] AM_INDY = 3'd6;
   localparam logic [2:0] AM_IND  = 3'd7;

   localparam logic [2:0] SEL_PC          = 3'd0;
   localparam logic [2:0] SEL_DIR_ZP      = 3'd1;
   localparam logic [2:0] SEL_DIR         = 3'd2;
   localparam logic [2:0] SEL_INDIR_ZP    = 3'd3;
   localparam logic [2:0] SEL_INDIR_ZP_P1 = 3'd4;
   localparam logic [2:0] SEL_INDIR       = 3'd5;
   localparam logic [2:0] SEL_INDIR_P1    = 3'd6;
   localparam logic [2:0] SEL_STACK       = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPL,
      ST_OPH,
      ST_IDX,
      ST_PTRL,
      ST_PTRH,
      ST_FIX,
      ST_DONE
   } am_state_t;

   // Modes whose first operand byte is an address byte rather than a pointer byte.
   function automatic logic is_direct_mode(input logic [2:0] mode);
      return (mode == AM_ZP) || (mode == AM_ZPX) || (mode == AM_ABS) ||
             (mode == AM_ABSX) || (mode == AM_ABSY);
   endfunction

   // Modes indexed by Y instead of X.
   function automatic logic uses_y_index(input logic [2:0] mode);
      return (mode == AM_ABSY) || (mode == AM_INDY);
   endfunction

endpackage

// File: rtl/addr_mode_sequencer_if.sv
// Bundle between the decoder/memory side and the addressing-mode sequencer.
// master: drives start/mode/data/index registers; slave: the sequencer itself.
interface addr_mode_sequencer_if;

   logic       start;
   logic [2:0] mode;
   logic [7:0] data_in;
   logic [7:0] x_reg;
   logic [7:0] y_reg;
   logic [2:0] address_select;
   logic       pc_inc;
   logic [7:0] dirl;
   logic [7:0] dirh;
   logic [7:0] indirl;
   logic [7:0] indirh;
   logic       busy;
   logic       done;

   modport master (
      output start, mode, data_in, x_reg, y_reg,
      input  address_select, pc_inc, dirl, dirh, indirl, indirh, busy, done
   );

   modport slave (
      input  start, mode, data_in, x_reg, y_reg,
      output address_select, pc_inc, dirl, dirh, indirl, indirh, busy, done
   );

endinterface

// File: rtl/addr_mode_sequencer.sv
// Walks the 6502 operand / effective-address fetch for one instruction:
// reads operand bytes at PC, applies X/Y indexing, follows pointers and
// leaves the final EA in dirh/dirl with the matching mux select on done.
module addr_mode_sequencer
   import cpu6502_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   addr_mode_sequencer_if.slave bus
);

   am_state_t  state, state_next;
   logic [2:0] mode_q, mode_next;
   logic [7:0] dirl_q, dirl_next;
   logic [7:0] dirh_q, dirh_next;
   logic [7:0] indirl_q, indirl_next;
   logic [7:0] indirh_q, indirh_next;
   logic [2:0] sel;
   logic       pc_inc;
   logic       busy;
   logic       done;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic [8:0] add_sum;

   // Single shared index adder; the carry out flags a page crossing.
   always_comb begin
      add_a = dirl_q;
      add_b = bus.x_reg;
      if (uses_y_index(mode_q)) begin
         add_b = bus.y_reg;
      end
      if (state == ST_IDX && mode_q == AM_INDX) begin
         add_a = indirl_q;
      end
      add_sum = {1'b0, add_a} + {1'b0, add_b};
   end

   // Next-state, register next values and per-state mux select / strobes.
   always_comb begin
      state_next  = state;
      mode_next   = mode_q;
      dirl_next   = dirl_q;
      dirh_next   = dirh_q;
      indirl_next = indirl_q;
      indirh_next = indirh_q;
      sel         = SEL_PC;
      pc_inc      = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;

      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (bus.start) begin
               mode_next  = bus.mode;
               state_next = ST_OPL;
            end
         end

         ST_OPL: begin
            pc_inc = 1'b1;
            if (is_direct_mode(mode_q)) begin
               dirl_next = bus.data_in;
            end else begin
               indirl_next = bus.data_in;
            end
            case (mode_q)
               AM_ZP:           state_next = ST_DONE;
               AM_ZPX, AM_INDX: state_next = ST_IDX;
               AM_INDY:         state_next = ST_PTRL;
               default:         state_next = ST_OPH;
            endcase
         end

         ST_OPH: begin
            pc_inc = 1'b1;
            if (mode_q == AM_IND) begin
               indirh_next = bus.data_in;
               state_next  = ST_PTRL;
            end else if (mode_q == AM_ABS) begin
               dirh_next  = bus.data_in;
               state_next = ST_DONE;
            end else begin
               dirh_next  = bus.data_in;
               dirl_next  = add_sum[7:0];
               state_next = add_sum[8] ? ST_FIX : ST_DONE;
            end
         end

         ST_IDX: begin
            if (mode_q == AM_INDX) begin
               indirl_next = add_sum[7:0];
               state_next  = ST_PTRL;
            end else begin
               dirl_next  = add_sum[7:0];
               state_next = ST_DONE;
            end
         end

         ST_PTRL: begin
            sel        = (mode_q == AM_IND) ? SEL_INDIR : SEL_INDIR_ZP;
            dirl_next  = bus.data_in;
            state_next = ST_PTRH;
         end

         ST_PTRH: begin
            sel       = (mode_q == AM_IND) ? SEL_INDIR_P1 : SEL_INDIR_ZP_P1;
            dirh_next = bus.data_in;
            if (mode_q == AM_INDY) begin
               dirl_next  = add_sum[7:0];
               state_next = add_sum[8] ? ST_FIX : ST_DONE;
            end else begin
               state_next = ST_DONE;
            end
         end

         ST_FIX: begin
            sel        = SEL_DIR;
            dirh_next  = dirh_q + 8'd1;
            state_next = ST_DONE;
         end

         ST_DONE: begin
            sel        = (mode_q == AM_ZP || mode_q == AM_ZPX) ? SEL_DIR_ZP : SEL_DIR;
            done       = 1'b1;
            state_next = ST_IDLE;
         end

         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and operand registers; reset abandons any sequence in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         mode_q   <= AM_ZP;
         dirl_q   <= 8'h00;
         dirh_q   <= 8'h00;
         indirl_q <= 8'h00;
         indirh_q <= 8'h00;
      end else begin
         state    <= state_next;
         mode_q   <= mode_next;
         dirl_q   <= dirl_next;
         dirh_q   <= dirh_next;
         indirl_q <= indirl_next;
         indirh_q <= indirh_next;
      end
   end

   assign bus.address_select = sel;
   assign bus.pc_inc         = pc_inc;
   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.dirl           = dirl_q;
   assign bus.dirh           = dirh_q;
   assign bus.indirl         = indirl_q;
   assign bus.indirh         = indirh_q;

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Testbench for addr_mode_sequencer: a 64 KB memory plus PC model answers the
// sequencer's reads, directed vectors and random sequences are compared
// against EA/cycle/pc_inc figures derived from the 6502 addressing rules.
module tb_addr_mode_sequencer;
   import cpu6502_pkg::*;

   logic clk = 1'b0;
   logic reset;

   addr_mode_sequencer_if bus ();

   addr_mode_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  mode;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [15:0] pc;
      logic [7:0]  op0;
      logic [7:0]  op1;
      logic [15:0] pa0;
      logic [7:0]  pd0;
      logic [15:0] pa1;
      logic [7:0]  pd1;
      logic [15:0] ea;
      int          cycles;
      int          incs;
      logic [2:0]  sel;
   } vec_t;

   vec_t        vecs [0:9];
   logic [7:0]  mem [0:65535];
   logic [15:0] pc;
   int          checks = 0;
   int          errors = 0;

   logic [2:0]  sel_trace  [0:31];
   logic [15:0] addr_trace [0:31];
   int          r_cycles;
   int          r_incs;
   logic [2:0]  r_sel;
   logic [15:0] r_ea;
   bit          r_timeout;
   bit          r_busy_ok;

   function automatic logic [15:0] mux_addr();
      logic [7:0] zp1;
      zp1 = bus.indirl + 8'd1;
      case (bus.address_select)
         3'd0:    return pc;
         3'd1:    return {8'h00, bus.dirl};
         3'd2:    return {bus.dirh, bus.dirl};
         3'd3:    return {8'h00, bus.indirl};
         3'd4:    return {8'h00, zp1};
         3'd5:    return {bus.indirh, bus.indirl};
         3'd6:    return {bus.indirh, bus.indirl} + 16'd1;
         default: return pc;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Reference: EA, cycle count, operand bytes consumed and final select.
   task automatic ref_model(input logic [2:0] m, input logic [7:0] x, input logic [7:0] y,
                            input logic [15:0] pc0, output logic [15:0] ea,
                            output int cyc, output int incs, output logic [2:0] sel);
      logic [15:0] pc1, base, ptr, ptr1;
      logic [7:0]  lo, idx, p, p1;
      pc1 = pc0 + 16'd1;
      lo  = mem[pc0];
      idx = (m == AM_ABSY || m == AM_INDY) ? y : x;
      ea = 16'h0000; cyc = 0; incs = 0; sel = 3'd2;
      case (m)
         AM_ZP:  begin ea = {8'h00, lo}; cyc = 2; incs = 1; sel = 3'd1; end
         AM_ZPX: begin p = lo + x; ea = {8'h00, p}; cyc = 3; incs = 1; sel = 3'd1; end
         AM_ABS, AM_ABSX, AM_ABSY: begin
            if (m == AM_ABS) idx = 8'h00;
            base = {mem[pc1], lo};
            ea   = base + {8'h00, idx};
            cyc  = 3 + ((int'(lo) + int'(idx) > 255) ? 1 : 0);
            incs = 2;
         end
         AM_INDX: begin
            p = lo + x; p1 = p + 8'd1;
            ea = {mem[{8'h00, p1}], mem[{8'h00, p}]};
            cyc = 5; incs = 1;
         end
         AM_INDY: begin
            p = lo; p1 = p + 8'd1;
            base = {mem[{8'h00, p1}], mem[{8'h00, p}]};
            ea   = base + {8'h00, y};
            cyc  = 4 + ((int'(base[7:0]) + int'(y) > 255) ? 1 : 0);
            incs = 1;
         end
         default: begin
            ptr = {mem[pc1], lo}; ptr1 = ptr + 16'd1;
            ea = {mem[ptr1], mem[ptr]};
            cyc = 5; incs = 2;
         end
      endcase
   endtask

   // Launch one sequence and service its memory reads until done or budget.
   task automatic apply_stimulus(input logic [2:0] m, input logic [7:0] x,
                                 input logic [7:0] y, input bit noise);
      bit got;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.mode    = m;
      bus.x_reg   = x;
      bus.y_reg   = y;
      bus.data_in = mem[mux_addr()];
      r_cycles = 0; r_incs = 0; r_timeout = 0; r_busy_ok = 1; got = 0;
      r_sel = 3'd0; r_ea = 16'h0000;
      while (!got && r_cycles < 24) begin
         @(posedge clk);
         @(negedge clk);
         r_cycles++;
         if (bus.busy !== 1'b1) r_busy_ok = 0;
         sel_trace[r_cycles]  = bus.address_select;
         addr_trace[r_cycles] = mux_addr();
         bus.data_in = mem[mux_addr()];
         if (bus.pc_inc === 1'b1) begin
            r_incs++;
            pc = pc + 16'd1;
         end
         if (bus.done === 1'b1) begin
            got   = 1;
            r_sel = bus.address_select;
            r_ea  = (bus.address_select == 3'd1) ? {8'h00, bus.dirl} : {bus.dirh, bus.dirl};
         end
         bus.start = noise;
         if (noise) bus.mode = 3'($urandom_range(0, 7));
      end
      if (!got) r_timeout = 1;
      if (noise && got) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
         check_output("done_start_ignored", {31'd0, bus.busy}, 32'd0);
      end
      bus.start = 1'b0;
   endtask

   task automatic run_vec(input int i, input bit noise);
      mem[vecs[i].pc]          = vecs[i].op0;
      mem[vecs[i].pc + 16'd1]  = vecs[i].op1;
      mem[vecs[i].pa0]         = vecs[i].pd0;
      mem[vecs[i].pa1]         = vecs[i].pd1;
      pc = vecs[i].pc;
      apply_stimulus(vecs[i].mode, vecs[i].x, vecs[i].y, noise);
      check_output($sformatf("vec%0d_timeout", i), {31'd0, r_timeout}, 32'd0);
      check_output($sformatf("vec%0d_ea", i), {16'd0, r_ea}, {16'd0, vecs[i].ea});
      check_output($sformatf("vec%0d_cycles", i), r_cycles, vecs[i].cycles);
      check_output($sformatf("vec%0d_pc_inc", i), r_incs, vecs[i].incs);
      check_output($sformatf("vec%0d_sel", i), {29'd0, r_sel}, {29'd0, vecs[i].sel});
      check_output($sformatf("vec%0d_busy", i), {31'd0, r_busy_ok}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] e_ea;
      int          e_cyc, e_incs, done_seen;
      logic [2:0]  e_sel, m;
      logic [7:0]  x, y;

      vecs[0] = '{AM_ZP,   8'h00, 8'h00, 16'h0200, 8'h42, 8'h00, 16'hF000, 8'h00, 16'hF001, 8'h00, 16'h0042, 2, 1, 3'd1};
      vecs[1] = '{AM_ZPX,  8'h20, 8'h00, 16'h0200, 8'hF0, 8'h00, 16'hF000, 8'h00, 16'hF001, 8'h00, 16'h0010, 3, 1, 3'd1};
      vecs[2] = '{AM_ABS,  8'h00, 8'h00, 16'h0200, 8'h34, 8'h12, 16'hF000, 8'h00, 16'hF001, 8'h00, 16'h1234, 3, 2, 3'd2};
      vecs[3] = '{AM_ABSX, 8'h20, 8'h00, 16'h0200, 8'hF0, 8'h12, 16'hF000, 8'h00, 16'hF001, 8'h00, 16'h1310, 4, 2, 3'd2};
      vecs[4] = '{AM_ABSX, 8'h05, 8'h00, 16'h0200, 8'hF0, 8'h12, 16'hF000, 8'h00, 16'hF001, 8'h00, 16'h12F5, 3, 2, 3'd2};
      vecs[5] = '{AM_ABSY, 8'h00, 8'h01, 16'h0200, 8'hFF, 8'hFF, 16'hF000, 8'h00, 16'hF001, 8'h00, 16'h0000, 4, 2, 3'd2};
      vecs[6] = '{AM_INDX, 8'h01, 8'h00, 16'h0200, 8'hFE, 8'h00, 16'h00FF, 8'h34, 16'h0000, 8'h12, 16'h1234, 5, 1, 3'd2};
      vecs[7] = '{AM_INDY, 8'h00, 8'h01, 16'h0200, 8'h10, 8'h00, 16'h0010, 8'hFF, 16'h0011, 8'h20, 16'h2100, 5, 1, 3'd2};
      vecs[8] = '{AM_INDY, 8'h00, 8'h05, 16'h0200, 8'h10, 8'h00, 16'h0010, 8'h10, 16'h0011, 8'h20, 16'h2015, 4, 1, 3'd2};
      vecs[9] = '{AM_IND,  8'h00, 8'h00, 16'h0200, 8'hFF, 8'h12, 16'h12FF, 8'h00, 16'h1300, 8'h80, 16'h8000, 5, 2, 3'd2};

      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      pc = 16'h0200;
      reset = 1'b1;
      bus.start = 1'b0; bus.mode = 3'd0; bus.data_in = 8'h00;
      bus.x_reg = 8'h00; bus.y_reg = 8'h00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_busy",   {31'd0, bus.busy}, 32'd0);
      check_output("reset_done",   {31'd0, bus.done}, 32'd0);
      check_output("reset_sel",    {29'd0, bus.address_select}, 32'd0);
      check_output("reset_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
      check_output("reset_regs",   {bus.dirh, bus.dirl, bus.indirh, bus.indirl}, 32'd0);
      reset = 1'b0;

      $display("[TB] directed vectors");
      for (int i = 0; i < 10; i++) run_vec(i, 1'b0);

      $display("[TB] pointer and page-fix corner sequences");
      run_vec(3, 1'b0);
      check_output("absx_fix_sel", {29'd0, sel_trace[3]}, 32'd2);
      run_vec(6, 1'b0);
      check_output("indx_ptrl_sel",  {29'd0, sel_trace[3]}, 32'd3);
      check_output("indx_ptrl_addr", {16'd0, addr_trace[3]}, 32'h00FF);
      check_output("indx_ptrh_sel",  {29'd0, sel_trace[4]}, 32'd4);
      check_output("indx_ptrh_addr", {16'd0, addr_trace[4]}, 32'h0000);
      run_vec(9, 1'b0);
      check_output("ind_ptrl_sel",  {29'd0, sel_trace[3]}, 32'd5);
      check_output("ind_ptrl_addr", {16'd0, addr_trace[3]}, 32'h12FF);
      check_output("ind_ptrh_sel",  {29'd0, sel_trace[4]}, 32'd6);
      check_output("ind_ptrh_addr", {16'd0, addr_trace[4]}, 32'h1300);

      $display("[TB] start and mode changes while busy");
      run_vec(3, 1'b1);
      run_vec(7, 1'b1);

      $display("[TB] reset during INDX pointer fetch");
      pc = 16'h0200;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = AM_INDX; bus.x_reg = 8'h01;
      bus.data_in = mem[mux_addr()];
      done_seen = 0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done === 1'b1) done_seen++;
         bus.data_in = mem[mux_addr()];
         if (bus.pc_inc === 1'b1) pc = pc + 16'd1;
      end
      check_output("abort_in_ptrl", {29'd0, bus.address_select}, 32'd3);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_output("abort_busy", {31'd0, bus.busy}, 32'd0);
      check_output("abort_sel",  {29'd0, bus.address_select}, 32'd0);
      check_output("abort_regs", {bus.dirh, bus.dirl, bus.indirh, bus.indirl}, 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done === 1'b1) done_seen++;
      end
      check_output("abort_no_done", done_seen, 0);

      $display("[TB] random sequences");
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int n = 0; n < 200; n++) begin
         m  = 3'($urandom_range(0, 7));
         x  = 8'($urandom);
         y  = 8'($urandom);
         pc = 16'($urandom);
         ref_model(m, x, y, pc, e_ea, e_cyc, e_incs, e_sel);
         apply_stimulus(m, x, y, 1'($urandom_range(0, 1)));
         check_output($sformatf("rnd%0d_m%0d_timeout", n, m), {31'd0, r_timeout}, 32'd0);
         check_output($sformatf("rnd%0d_m%0d_ea", n, m), {16'd0, r_ea}, {16'd0, e_ea});
         check_output($sformatf("rnd%0d_m%0d_cycles", n, m), r_cycles, e_cyc);
         check_output($sformatf("rnd%0d_m%0d_pc_inc", n, m), r_incs, e_incs);
         check_output($sformatf("rnd%0d_m%0d_sel", n, m), {29'd0, r_sel}, {29'd0, e_sel});
         check_output($sformatf("rnd%0d_m%0d_busy", n, m), {31'd0, r_busy_ok}, 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
